// File: rtl/vram_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : vram_scheduler                                               |
// | Description : Arbitrates one synchronous single-port video RAM between the |
// |               scan-out fetch (fixed slots) and a CPU req/ready port. Owns  |
// |               the frame base, which is swapped only during vblank.         |
// | Option      : VRAM_CPU_BLANK_ONLY_EN - CPU is granted only outside active  |
// |               video, for RAMs that cannot interleave with scan-out.        |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module vram_scheduler #(
    parameter int                      H_REG_MAX          = 11,
    parameter int                      V_REG_MAX          = 11,
    parameter int                      V_VISIBLE_AREA     = 480,
    parameter int                      PIXELS_PER_WORD    = 4,
    parameter int                      ADDR_WIDTH         = 16,
    parameter int                      DATA_WIDTH         = 16,
    parameter logic [ADDR_WIDTH-1:0]   FRAME_BASE_DEFAULT = '0
) (
    input  logic                   pixel_clock,
    input  logic                   reset,
    input  logic [H_REG_MAX:0]     h_position,
    input  logic [V_REG_MAX:0]     v_position,
    input  logic                   visible_area,
    input  logic                   cpu_req,
    input  logic                   cpu_we,
    input  logic [ADDR_WIDTH-1:0]  cpu_addr,
    input  logic [DATA_WIDTH-1:0]  cpu_wdata,
    output logic                   cpu_ready,
    output logic [DATA_WIDTH-1:0]  cpu_rdata,
    output logic                   cpu_rvalid,
    input  logic                   base_we,
    input  logic [ADDR_WIDTH-1:0]  base_addr,
    output logic                   mem_en,
    output logic                   mem_we,
    output logic [ADDR_WIDTH-1:0]  mem_addr,
    output logic [DATA_WIDTH-1:0]  mem_wdata,
    input  logic [DATA_WIDTH-1:0]  mem_rdata,
    output logic [DATA_WIDTH-1:0]  display_word,
    output logic                   display_word_valid
);

    // Low h_position bits that select the pixel within a RAM word.
    localparam int                    c_SEL_W     = $clog2(PIXELS_PER_WORD);
    localparam logic [V_REG_MAX:0]    c_V_VISIBLE = V_VISIBLE_AREA[V_REG_MAX:0];
    localparam logic [ADDR_WIDTH-1:0] c_ADDR_ONE  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

    // Return tags: which requester owns the RAM data coming back.
    localparam logic [1:0] c_TAG_NONE = 2'd0;
    localparam logic [1:0] c_TAG_DISP = 2'd1;
    localparam logic [1:0] c_TAG_CPU  = 2'd2;

    logic                  w_display_slot;
    logic                  w_vblank;
    logic                  w_cpu_gate;
    logic                  w_cpu_accept;
    logic                  w_unused;

    logic [1:0]            r_tag_s1;
    logic [1:0]            r_tag_s2;
    logic [ADDR_WIDTH-1:0] r_pending_base;
    logic [ADDR_WIDTH-1:0] r_active_base;
    logic [ADDR_WIDTH-1:0] r_fetch_ptr;

    // The word-select bits decide slots; the rest of h_position is not needed.
    assign w_unused = &{1'b0, h_position[H_REG_MAX:c_SEL_W]};

    assign w_display_slot = visible_area && (h_position[c_SEL_W-1:0] == '0);
    assign w_vblank       = (v_position >= c_V_VISIBLE);

`ifdef VRAM_CPU_BLANK_ONLY_EN
    // RAM cannot interleave: keep the CPU off the bus for all of active video.
    assign w_cpu_gate = !visible_area;
`else
    assign w_cpu_gate = 1'b1;
`endif

    // Display owns its slot outright; the CPU takes any other cycle.
    assign cpu_ready    = cpu_req && !w_display_slot && !reset && w_cpu_gate;
    assign w_cpu_accept = cpu_ready;

    // Read data is routed by the tag that travelled alongside the access.
    // Gating with reset kills a pulse for a read already in flight.
    assign display_word       = mem_rdata;
    assign display_word_valid = (r_tag_s2 == c_TAG_DISP) && !reset;
    assign cpu_rdata          = mem_rdata;
    assign cpu_rvalid         = (r_tag_s2 == c_TAG_CPU) && !reset;

    // Registered RAM strobes: display slot first, then CPU, else idle (address/data hold).
    always_ff @(posedge pixel_clock) begin
        if (reset) begin
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else if (w_display_slot) begin
            mem_en    <= 1'b1;
            mem_we    <= 1'b0;
            mem_addr  <= r_fetch_ptr;
        end else if (w_cpu_accept) begin
            mem_en    <= 1'b1;
            mem_we    <= cpu_we;
            mem_addr  <= cpu_addr;
            mem_wdata <= cpu_wdata;
        end else begin
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
        end
    end

    // Two-stage tag pipe: stage 1 lines up with the RAM strobe, stage 2 with its data.
    always_ff @(posedge pixel_clock) begin
        if (reset) begin
            r_tag_s1 <= c_TAG_NONE;
            r_tag_s2 <= c_TAG_NONE;
        end else begin
            if (w_display_slot) begin
                r_tag_s1 <= c_TAG_DISP;
            end else if (w_cpu_accept && !cpu_we) begin
                r_tag_s1 <= c_TAG_CPU;
            end else begin
                r_tag_s1 <= c_TAG_NONE;
            end
            r_tag_s2 <= r_tag_s1;
        end
    end

    // Frame base and fetch pointer: swaps only in vblank so a frame never tears;
    // during active video the pointer just walks through contiguous lines.
    always_ff @(posedge pixel_clock) begin
        if (reset) begin
            r_pending_base <= FRAME_BASE_DEFAULT;
            r_active_base  <= FRAME_BASE_DEFAULT;
            r_fetch_ptr    <= FRAME_BASE_DEFAULT;
        end else begin
            if (base_we) begin
                r_pending_base <= base_addr;
            end
            if (w_vblank) begin
                r_active_base <= r_pending_base;
                r_fetch_ptr   <= r_active_base;
            end else if (w_display_slot) begin
                r_fetch_ptr   <= r_fetch_ptr + c_ADDR_ONE;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_vram_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_vram_scheduler                                            |
// | Description : Directed self-checking bench for vram_scheduler with a       |
// |               behavioural synchronous RAM. Positions are driven directly.  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_vram_scheduler;

    logic        pixel_clock = 1'b0;
    logic        reset;
    logic [11:0] h_position;
    logic [11:0] v_position;
    logic        visible_area;
    logic        cpu_req;
    logic        cpu_we;
    logic [15:0] cpu_addr;
    logic [15:0] cpu_wdata;
    logic        cpu_ready;
    logic [15:0] cpu_rdata;
    logic        cpu_rvalid;
    logic        base_we;
    logic [15:0] base_addr;
    logic        mem_en;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic [15:0] display_word;
    logic        display_word_valid;

    int n_checks = 0;
    int n_fail   = 0;
    int n_fetch  = 0;

    logic [15:0] ram [0:65535];
    logic [15:0] ram_q;

    vram_scheduler dut (
        .pixel_clock        (pixel_clock),
        .reset              (reset),
        .h_position         (h_position),
        .v_position         (v_position),
        .visible_area       (visible_area),
        .cpu_req            (cpu_req),
        .cpu_we             (cpu_we),
        .cpu_addr           (cpu_addr),
        .cpu_wdata          (cpu_wdata),
        .cpu_ready          (cpu_ready),
        .cpu_rdata          (cpu_rdata),
        .cpu_rvalid         (cpu_rvalid),
        .base_we            (base_we),
        .base_addr          (base_addr),
        .mem_en             (mem_en),
        .mem_we             (mem_we),
        .mem_addr           (mem_addr),
        .mem_wdata          (mem_wdata),
        .mem_rdata          (mem_rdata),
        .display_word       (display_word),
        .display_word_valid (display_word_valid)
    );

    always #5 pixel_clock = ~pixel_clock;

    // Synchronous single-port RAM; preloaded with known patterns while in reset.
    always @(posedge pixel_clock) begin
        if (reset) begin
            for (int i = 0; i < 256; i++) begin
                ram[16'h1000 + 16'(i)] <= 16'hA000 + 16'(i);
            end
            ram[16'h0042] <= 16'hBEEF;
            ram[16'h2000] <= 16'h5A5A;
            ram[16'h2001] <= 16'h5A5B;
            ram_q         <= 16'h0000;
        end else if (mem_en) begin
            if (mem_we) begin
                ram[mem_addr] <= mem_wdata;
            end else begin
                ram_q <= ram[mem_addr];
            end
        end
    end
    assign mem_rdata = ram_q;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s observed=%h expected=%h at t=%0t", tag, obs, exp, $time);
        end
    endtask

    // Advance to the next cycle and present a new raster position.
    task automatic next_cycle(input int h, input int v);
        @(posedge pixel_clock);
        #1;
        h_position   = h[11:0];
        v_position   = v[11:0];
        visible_area = (h < 640) && (v < 480);
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        base_we = 1'b0; base_addr = '0;
        h_position = 12'd700; v_position = 12'd10; visible_area = 1'b0;
        repeat (3) next_cycle(700, 10);

        // Reset state
        next_cycle(700, 10); reset = 1'b0; settle();
        check_val("rst_mem_en", mem_en, 0);
        check_val("rst_mem_we", mem_we, 0);
        check_val("rst_mem_addr", mem_addr, 0);
        check_val("rst_mem_wdata", mem_wdata, 0);
        check_val("rst_rvalid", cpu_rvalid, 0);
        check_val("rst_dvalid", display_word_valid, 0);

        // Test 1: read accepted, reset the next cycle -> no return pulse
        next_cycle(700, 10); cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0042; settle();
        check_val("t1_ready", cpu_ready, 1);
        next_cycle(701, 10); reset = 1'b1; settle();
        check_val("t1_ready_in_reset", cpu_ready, 0);
        check_val("t1_rvalid_in_reset", cpu_rvalid, 0);
        next_cycle(702, 10); reset = 1'b0; cpu_req = 1'b0; settle();
        check_val("t1_rvalid_after", cpu_rvalid, 0);
        check_val("t1_mem_en", mem_en, 0);
        check_val("t1_mem_addr", mem_addr, 0);
        check_val("t1_dvalid", display_word_valid, 0);
        next_cycle(703, 10); settle();
        check_val("t1_rvalid_late", cpu_rvalid, 0);

        // Test 4: CPU read in hblank
        next_cycle(710, 10); cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0042; settle();
        check_val("t4_ready", cpu_ready, 1);
        next_cycle(711, 10); cpu_req = 1'b0; settle();
        check_val("t4_mem_en", mem_en, 1);
        check_val("t4_mem_we", mem_we, 0);
        check_val("t4_mem_addr", mem_addr, 16'h0042);
        check_val("t4_rvalid_early", cpu_rvalid, 0);
        next_cycle(712, 10); settle();
        check_val("t4_rvalid", cpu_rvalid, 1);
        check_val("t4_rdata", cpu_rdata, 16'hBEEF);
        check_val("t4_dvalid", display_word_valid, 0);
        next_cycle(713, 10); settle();
        check_val("t4_rvalid_off", cpu_rvalid, 0);
        check_val("t4_idle_en", mem_en, 0);
        check_val("t4_idle_addr_hold", mem_addr, 16'h0042);

        // Load base 0x1000, let vblank apply it
        next_cycle(720, 10); base_we = 1'b1; base_addr = 16'h1000; settle();
        next_cycle(721, 10); base_we = 1'b0; settle();
        for (int i = 0; i < 3; i++) next_cycle(i, 480);

        // Test 2: first visible line fetches 0x1000.. every 4 clocks
        for (int h = 0; h < 644; h++) begin
            next_cycle(h, 0); settle();
            if (mem_en && !mem_we) n_fetch++;
            if ((h >= 1) && (h - 1 < 640) && ((h - 1) % 4 == 0)) begin
                check_val("t2_fetch_en", {mem_en, mem_we}, 2'b10);
                check_val("t2_fetch_addr", mem_addr, 32'h1000 + (h - 1) / 4);
            end else begin
                check_val("t2_idle_en", mem_en, 0);
            end
            if ((h >= 2) && (h - 2 < 640) && ((h - 2) % 4 == 0)) begin
                check_val("t2_dvalid", display_word_valid, 1);
                check_val("t2_dword", display_word, 32'hA000 + (h - 2) / 4);
            end else begin
                check_val("t2_dvalid_off", display_word_valid, 0);
            end
        end
        check_val("t2_fetch_count", n_fetch, 160);

        // Test 3: CPU write held across slot h=8 on line 1
        for (int h = 0; h < 8; h++) next_cycle(h, 1);
        next_cycle(8, 1);
`ifndef VRAM_CPU_BLANK_ONLY_EN
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h0055; cpu_wdata = 16'h1234;
`endif
        settle();
        check_val("t3_ready_slot", cpu_ready, 0);
        next_cycle(9, 1); settle();
`ifndef VRAM_CPU_BLANK_ONLY_EN
        check_val("t3_ready_after", cpu_ready, 1);
`endif
        check_val("t3_slot_en", {mem_en, mem_we}, 2'b10);
        check_val("t3_slot_addr", mem_addr, 16'h10A2);
        next_cycle(10, 1); cpu_req = 1'b0; settle();
`ifndef VRAM_CPU_BLANK_ONLY_EN
        check_val("t3_wr_strobe", {mem_en, mem_we}, 2'b11);
        check_val("t3_wr_addr", mem_addr, 16'h0055);
        check_val("t3_wr_data", mem_wdata, 16'h1234);
`else
        check_val("t3_blank_only_idle", mem_en, 0);
`endif
        check_val("t3_dvalid", display_word_valid, 1);
        check_val("t3_dword", display_word, 16'hA0A2);
        next_cycle(11, 1); settle();
        check_val("t3_no_wr_return", cpu_rvalid, 0);
`ifndef VRAM_CPU_BLANK_ONLY_EN
        next_cycle(700, 1); cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0055; settle();
        next_cycle(701, 1); cpu_req = 1'b0; settle();
        next_cycle(702, 1); settle();
        check_val("t3_readback_v", cpu_rvalid, 1);
        check_val("t3_readback_d", cpu_rdata, 16'h1234);
`endif

        // Test 5: base write mid-frame takes effect next frame only
        next_cycle(700, 100); base_we = 1'b1; base_addr = 16'h2000; settle();
        next_cycle(701, 100); base_we = 1'b0; settle();
        next_cycle(0, 101); settle();
        next_cycle(1, 101); settle();
        check_val("t5_old_base_addr", mem_addr, 16'h10A3);
        next_cycle(2, 101); settle();
        check_val("t5_old_base_word", display_word, 16'hA0A3);
        next_cycle(0, 480); settle();
        next_cycle(1, 480); settle();
        check_val("t5_vblank_idle", mem_en, 0);
        check_val("t5_vblank_hold", mem_addr, 16'h10A3);
        next_cycle(2, 480); settle();
        next_cycle(0, 0); settle();
        next_cycle(1, 0); settle();
        check_val("t5_new_base_addr0", mem_addr, 16'h2000);
        next_cycle(2, 0); settle();
        check_val("t5_new_base_word0", display_word, 16'h5A5A);
        for (int h = 3; h < 5; h++) next_cycle(h, 0);
        next_cycle(5, 0); settle();
        check_val("t5_new_base_addr1", mem_addr, 16'h2001);

        // Test 6: CPU grant in non-slot cycles of active video
        next_cycle(0, 1);
`ifdef VRAM_CPU_BLANK_ONLY_EN
        for (int h = 1; h <= 640; h++) begin
            next_cycle(h, 1); cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0042; settle();
            check_val("t6_blank_only_ready", cpu_ready, (h == 640) ? 1 : 0);
        end
        next_cycle(641, 1); cpu_req = 1'b0; settle();
        check_val("t6_accept_addr", mem_addr, 16'h0042);
        next_cycle(642, 1); settle();
        check_val("t6_rdata", cpu_rdata, 16'hBEEF);
        check_val("t6_rvalid", cpu_rvalid, 1);
`else
        next_cycle(1, 1); cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0042; settle();
        check_val("t6_ready_visible", cpu_ready, 1);
        next_cycle(2, 1); cpu_req = 1'b0; settle();
        check_val("t6_accept_addr", mem_addr, 16'h0042);
        check_val("t6_dvalid", display_word_valid, 1);
        check_val("t6_rvalid_early", cpu_rvalid, 0);
        next_cycle(3, 1); settle();
        check_val("t6_rvalid", cpu_rvalid, 1);
        check_val("t6_rdata", cpu_rdata, 16'hBEEF);
        check_val("t6_dvalid_off", display_word_valid, 0);
        next_cycle(4, 1); cpu_req = 1'b1; settle();
        check_val("t6_ready_slot", cpu_ready, 0);
        next_cycle(5, 1); settle();
        check_val("t6_ready_resume", cpu_ready, 1);
        next_cycle(6, 1); cpu_req = 1'b0; settle();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
